vdp_host_master: RTL and testbench

//  Bus initiator for the VDP CPU port: converts a simple command handshake into Z80-style
//  IN/OUT strobe cycles on the VDP data/control ports (TMS9918A protocol). Sits between an
//  on-chip soft CPU/DMA and the VDP top level; also synchronises the VDP interrupt line.

---
 rtl/vdp_host_master.sv | 137 +++++++++++++
 tb/tb_vdp_host_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_host_master.sv
// vdp_host_master: turns command handshakes into TMS9918A-style IN/OUT strobe cycles,
// skipping VRAM address setup when the VDP auto-increment pointer already matches.
module vdp_host_master #(
  parameter logic [7:0] PORT_BASE  = 8'h98,
  parameter int         STROBE_CYC = 4,
  parameter int         GAP_CYC    = 8
) (
  input  logic        clk40m,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [13:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [7:0]  bus_a,
  output logic [7:0]  bus_dout,
  output logic        bus_doe,
  input  logic [7:0]  bus_din,
  output logic        bus_out_n,
  output logic        bus_in_n,
  input  logic        bus_int_n,
  output logic        irq
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;
  state_t      state;
  logic [1:0]  op, idx, start_idx;
  logic [13:0] addr, ptr;
  logic [7:0]  data, rd_buf, cnt;
  logic        ptr_valid, ptr_rd, sync1, sync2, cur_rd, adv;
  logic [9:0]  first, nxt;
  // Access slot i of op o as {read, control port, byte}; slots 0/1 are setup, slot 2 the data/status access.
  function automatic logic [9:0] acc(input logic [1:0] o, input logic [13:0] a, input logic [7:0] d,
                                     input logic [1:0] i);
    return i == 2'd0 ? {2'b01, o == 2'd0 ? d : a[7:0]} :
           i == 2'd1 ? {2'b01, o == 2'd0 ? {5'b10000, a[2:0]} : {1'b0, ~o[1], a[13:8]}} :
                       {o[1], o == 2'd3, d};
  endfunction
  always_comb begin
    start_idx = (cmd_op == 2'd3 || (cmd_op != 2'd0 && ptr_valid && ptr_rd == cmd_op[1] && ptr == cmd_addr))
                ? 2'd2 : 2'd0;
    first = acc(cmd_op, cmd_addr, cmd_data, start_idx);
    nxt = acc(op, addr, data, idx + 2'd1);
    cur_rd = op[1] && idx == 2'd2;
    adv = (state == GAP && cnt == 8'd0) || (state == HOLD && GAP_CYC == 0);
  end
  always_ff @(posedge clk40m or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= 8'd0;
      bus_a <= 8'd0;
      bus_dout <= 8'd0;
      bus_doe <= 1'b0;
      bus_out_n <= 1'b1;
      bus_in_n <= 1'b1;
      op <= 2'd0;
      idx <= 2'd0;
      addr <= 14'd0;
      data <= 8'd0;
      rd_buf <= 8'd0;
      cnt <= 8'd0;
      ptr <= 14'd0;
      ptr_valid <= 1'b0;
      ptr_rd <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            op <= cmd_op;
            addr <= cmd_addr;
            data <= cmd_data;
            idx <= start_idx;
            cmd_ready <= 1'b0;
            state <= SETUP;
            bus_a <= first[8] ? PORT_BASE + 8'd1 : PORT_BASE;
            bus_dout <= first[7:0];
            bus_doe <= ~first[9];
            if (cmd_op == 2'd0) ptr_valid <= 1'b0;
          end
        end
        SETUP: begin
          cnt <= 8'(STROBE_CYC - 1);
          bus_out_n <= cur_rd;
          bus_in_n <= ~cur_rd;
          state <= STROBE;
        end
        STROBE:
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          else begin
            bus_out_n <= 1'b1;
            bus_in_n <= 1'b1;
            if (cur_rd) rd_buf <= bus_din;
            state <= HOLD;
          end
        HOLD: begin
          if ((op == 2'd1 || op == 2'd2) && idx == 2'd2) begin
            ptr <= addr + 14'd1;
            ptr_valid <= 1'b1;
            ptr_rd <= op[1];
          end
          bus_doe <= 1'b0;
          cnt <= 8'(GAP_CYC - 1);
          state <= GAP;
        end
        GAP: if (cnt != 8'd0) cnt <= cnt - 8'd1;
        default: state <= IDLE;
      endcase
      if (adv) begin
        if (idx == (op == 2'd0 ? 2'd1 : 2'd2)) begin
          state <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= op[1];
          if (op[1]) rsp_data <= rd_buf;
        end else begin
          idx <= idx + 2'd1;
          state <= SETUP;
          bus_a <= nxt[8] ? PORT_BASE + 8'd1 : PORT_BASE;
          bus_dout <= nxt[7:0];
          bus_doe <= ~nxt[9];
        end
      end
    end
  always_ff @(posedge clk40m or negedge rst_n)
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus_int_n;
      sync2 <= sync1;
    end
  assign irq = ~sync2;
endmodule

// File: tb/tb_vdp_host_master.sv
// tb_vdp_host_master: command-level reference model checked against the bus every cycle,
// plus directed sequences with hand-computed bus traces.
module tb_vdp_host_master;
  localparam int S = 4, G = 8, T = S + G + 2;
  localparam logic [7:0] PD = 8'h98, PC = 8'h99;
  logic clk40m = 0, rst_n = 0, cmd_valid = 0, bus_int_n = 1;
  logic [1:0] cmd_op = 0;
  logic [13:0] cmd_addr = 0;
  logic [7:0] cmd_data = 0, bus_din = 0;
  logic cmd_ready, rsp_valid, bus_doe, bus_out_n, bus_in_n, irq;
  logic [7:0] rsp_data, bus_a, bus_dout;

  vdp_host_master dut (.clk40m(clk40m), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bus_a(bus_a), .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(bus_din), .bus_out_n(bus_out_n),
    .bus_in_n(bus_in_n), .bus_int_n(bus_int_n), .irq(irq));

  initial forever #5 clk40m = ~clk40m;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Reference model: accesses of the current command, timed from its accept edge.
  typedef struct {bit rd; bit [7:0] a; bit [7:0] d;} acc_t;
  acc_t m_acc[3];
  int m_n = 0, m_k = 0, pc = 0, ready_at = 1 << 30, force_din = -1;
  bit [13:0] m_ptr = 0;
  bit m_pv = 0, m_prd = 0, m_pend = 0;
  bit [7:0] m_rdval = 0, m_rsp = 0;

  function automatic void push(bit rd, bit [7:0] a, bit [7:0] d);
    m_acc[m_n] = '{rd, a, d};
    m_n++;
  endfunction

  function automatic void model_accept();
    bit rd;
    m_n = 0;
    case (cmd_op)
      2'd0: begin
        push(0, PC, cmd_data);
        push(0, PC, {5'b10000, cmd_addr[2:0]});
        m_pv = 0;
      end
      2'd3: push(1, PC, 8'h00);
      default: begin
        rd = cmd_op == 2'd2;
        if (!(m_pv && m_prd == rd && m_ptr == cmd_addr)) begin
          push(0, PC, cmd_addr[7:0]);
          push(0, PC, rd ? {2'b00, cmd_addr[13:8]} : {2'b01, cmd_addr[13:8]});
        end
        push(rd, PD, cmd_data);
        m_ptr = cmd_addr + 14'd1;
        m_pv = 1;
        m_prd = rd;
      end
    endcase
    m_pend = cmd_op[1];
    m_rdval = force_din >= 0 ? 8'(force_din) : 8'($urandom);
    m_k = pc + 1;
    ready_at = m_k + m_n * T;
  endfunction

  always @(posedge clk40m) begin
    if (!rst_n) begin
      pc++;
      ready_at = pc + 1;
      m_n = 0;
      m_pend = 0;
      m_pv = 0;
      m_rsp = 0;
    end else begin
      if (cmd_valid && pc >= ready_at) model_accept();
      pc++;
    end
  end

  bit e_rdy, e_out, e_in, e_doe, ca, cd, e_rv, ok;
  bit [7:0] e_a, e_d;
  int b;
  always @(negedge clk40m) begin
    bus_din = 8'($urandom);
    n_cmp++;
    if (!rst_n) begin
      if (cmd_ready !== 0 || bus_out_n !== 1 || bus_in_n !== 1 || bus_doe !== 0 || bus_a !== 0 ||
          bus_dout !== 0 || rsp_valid !== 0 || rsp_data !== 0) begin
        n_bad++;
        $display("FAIL reset_state: got rdy=%b out=%b in=%b doe=%b a=%h d=%h rv=%b rd=%h want all idle/zero",
                 cmd_ready, bus_out_n, bus_in_n, bus_doe, bus_a, bus_dout, rsp_valid, rsp_data);
      end
    end else begin
      e_out = 1; e_in = 1; e_doe = 0; ca = 0; cd = 0; e_rv = 0; e_a = 0; e_d = 0;
      for (int j = 0; j < m_n; j++) begin
        b = m_k + j * T;
        if (pc >= b && pc <= b + S + 1) begin
          ca = 1;
          e_a = m_acc[j].a;
          if (!m_acc[j].rd) begin
            cd = 1;
            e_d = m_acc[j].d;
            e_doe = 1;
          end
          if (pc > b && pc <= b + S) begin
            if (m_acc[j].rd) e_in = 0;
            else e_out = 0;
          end
          if (m_acc[j].rd && pc == b + S) bus_din = m_rdval;
        end
      end
      if (m_pend && pc == ready_at) begin
        e_rv = 1;
        m_rsp = m_rdval;
        m_pend = 0;
      end
      e_rdy = pc >= ready_at;
      ok = cmd_ready === e_rdy && bus_out_n === e_out && bus_in_n === e_in && bus_doe === e_doe &&
           (!ca || bus_a === e_a) && (!cd || bus_dout === e_d) && rsp_valid === e_rv && rsp_data === m_rsp;
      if (!ok) begin
        n_bad++;
        $display("FAIL cycle %0d: got rdy=%b out=%b in=%b doe=%b a=%h d=%h rv=%b rd=%h want rdy=%b out=%b in=%b doe=%b a=%h d=%h rv=%b rd=%h",
                 pc, cmd_ready, bus_out_n, bus_in_n, bus_doe, bus_a, bus_dout, rsp_valid, rsp_data,
                 e_rdy, e_out, e_in, e_doe, e_a, e_d, e_rv, m_rsp);
      end
    end
  end

  // Bus observer for the directed traces: {read, port, byte} per strobe, plus last strobe width.
  logic [16:0] obs_q[$];
  bit p_out = 1, p_in = 1;
  int w = 0, last_w = 0;
  always @(negedge clk40m) begin
    if (rst_n && ((!bus_out_n && p_out) || (!bus_in_n && p_in)))
      obs_q.push_back({!bus_in_n, bus_a, bus_in_n ? bus_dout : 8'h00});
    if (!bus_out_n || !bus_in_n) w++;
    else if (w > 0) begin
      last_w = w;
      w = 0;
    end
    p_out = bus_out_n;
    p_in = bus_in_n;
  end

  function automatic logic [16:0] wr(bit [7:0] a, bit [7:0] d);
    return {1'b0, a, d};
  endfunction
  function automatic logic [16:0] rd(bit [7:0] a);
    return {1'b1, a, 8'h00};
  endfunction

  task automatic chk_log(input string nm, input int n, input logic [16:0] e0, e1, e2);
    logic [16:0] e[3];
    e = '{e0, e1, e2};
    check({nm, "_len"}, obs_q.size(), n);
    for (int i = 0; i < n; i++) check(nm, i < obs_q.size() ? int'(obs_q[i]) : -1, int'(e[i]));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1 && n < 300) begin
      @(negedge clk40m);
      n++;
    end
    if (cmd_ready !== 1) check("ready_wait", int'(cmd_ready), 1);
  endtask

  task automatic run(input [1:0] op, input [13:0] a, input [7:0] d, output int lat);
    wait_ready();
    obs_q.delete();
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_data = d;
    lat = 0;
    do begin
      @(negedge clk40m);
      lat++;
      if (lat == 1) begin
        cmd_valid = 0; cmd_op = 2'($urandom); cmd_addr = 14'($urandom); cmd_data = 8'($urandom);
      end
    end while (cmd_ready !== 1 && lat < 100);
  endtask

  int lat, nacc, guard;
  initial begin
    repeat (3) @(negedge clk40m);
    check("rst_ready", cmd_ready, 0);
    check("rst_strobes", {bus_out_n, bus_in_n, bus_doe}, 3'b110);
    check("rst_bus", {bus_a, bus_dout}, 0);
    check("rst_rsp", {rsp_valid, rsp_data}, 0);
    check("rst_irq", irq, 0);
    rst_n = 1;
    @(negedge clk40m);
    check("ready_after_rst", cmd_ready, 1);

    run(2'd0, 14'd1, 8'hE0, lat);
    check("op0_lat", lat, 29);
    chk_log("op0", 2, wr(PC, 8'hE0), wr(PC, 8'h81), 0);
    check("op0_width", last_w, S);
    run(2'd1, 14'h1800, 8'h55, lat);
    check("op1_full_lat", lat, 43);
    chk_log("op1_full", 3, wr(PC, 8'h00), wr(PC, 8'h58), wr(PD, 8'h55));
    run(2'd1, 14'h1801, 8'hAA, lat);
    check("op1_skip_lat", lat, 15);
    chk_log("op1_skip", 1, wr(PD, 8'hAA), 0, 0);
    run(2'd1, 14'h3FFF, 8'h11, lat);
    chk_log("op1_3fff", 3, wr(PC, 8'hFF), wr(PC, 8'h7F), wr(PD, 8'h11));
    run(2'd1, 14'h0000, 8'h22, lat);
    check("op1_wrap_lat", lat, 15);
    chk_log("op1_wrap", 1, wr(PD, 8'h22), 0, 0);
    run(2'd1, 14'h0005, 8'h33, lat);
    chk_log("op1_0005", 3, wr(PC, 8'h05), wr(PC, 8'h40), wr(PD, 8'h33));
    force_din = 8'h9F;
    run(2'd3, 14'h0000, 8'h00, lat);
    check("op3_lat", lat, 15);
    chk_log("op3", 1, rd(PC), 0, 0);
    check("op3_rsp_valid", rsp_valid, 1);
    check("op3_rsp_data", rsp_data, 8'h9F);
    @(negedge clk40m);
    check("op3_rsp_pulse", rsp_valid, 0);
    check("op3_rsp_hold", rsp_data, 8'h9F);
    force_din = 8'hC3;
    run(2'd2, 14'h0006, 8'h00, lat);
    check("op2_lat", lat, 43);
    chk_log("op2_mode", 3, wr(PC, 8'h06), wr(PC, 8'h00), rd(PD));
    check("op2_rsp_data", rsp_data, 8'hC3);
    force_din = -1;

    run(2'd1, 14'h0100, 8'h77, lat);
    wait_ready();
    cmd_valid = 1; cmd_op = 2'd0; cmd_addr = 14'd2; cmd_data = 8'h12;
    @(negedge clk40m);
    cmd_valid = 0;
    repeat (T + 2) @(negedge clk40m);
    check("mid_strobe_low", bus_out_n, 0);
    #2 rst_n = 0;
    #1 check("rst_async_strobe", bus_out_n, 1);
    check("rst_async_ready", cmd_ready, 0);
    repeat (2) @(negedge clk40m);
    check("rst_no_rsp", rsp_valid, 0);
    rst_n = 1;
    run(2'd1, 14'h0101, 8'h5A, lat);
    check("post_rst_lat", lat, 43);
    chk_log("post_rst", 3, wr(PC, 8'h01), wr(PC, 8'h41), wr(PD, 8'h5A));

    @(negedge clk40m);
    #3 bus_int_n = 0;
    #1 check("irq_sync_delay", irq, 0);
    repeat (3) @(posedge clk40m);
    #1 check("irq_assert", irq, 1);
    #2 bus_int_n = 1;
    repeat (3) @(posedge clk40m);
    #1 check("irq_release", irq, 0);

    nacc = 0;
    guard = 0;
    while (nacc < 80 && guard < 20000) begin
      @(negedge clk40m);
      guard++;
      cmd_valid = 0;
      cmd_op = 2'($urandom); cmd_data = 8'($urandom);
      case ($urandom % 4)
        0, 1: cmd_addr = m_ptr;
        2: cmd_addr = 14'h3FFF;
        default: cmd_addr = 14'($urandom);
      endcase
      if (pc >= ready_at) begin
        if ($urandom % 3 != 0) begin
          cmd_valid = 1;
          nacc++;
        end
      end else if ($urandom % 5 == 0) cmd_valid = 1;
    end
    check("random_cmds", nacc, 80);
    cmd_valid = 0;
    repeat (3 * T + 5) @(negedge clk40m);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
